// File: rtl/mcca_pkg.sv
// Shared definitions for the dynamic Manchester carry-chain adder sequencer.
// Holds the state encoding, default parameters and the phase-counter width helper.
package mcca_pkg;

  localparam int unsigned SIZE_DEF  = 16;
  localparam int unsigned PRECH_DEF = 1;
  localparam int unsigned EVAL_DEF  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRECH = 2'd1,
    EVAL  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Phase counter must hold the longer of the two phase lengths.
  function automatic int unsigned cnt_width(input int unsigned p, input int unsigned e);
    int unsigned m;
    m = (p > e) ? p : e;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/mcca_phase_timer.sv
// Loadable down-counter shared by the precharge and evaluate phases.
// o_done_c is high while the count is zero, i.e. during the last cycle of a phase.
module mcca_phase_timer #(
  parameter int unsigned CW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  input  logic          i_en,
  output logic          o_done_c
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_done_c = (r_cnt == '0);

endmodule

// File: rtl/mcca_dyn_sequencer.sv
// Operand stage and precharge/evaluate phase controller for the dynamic carry-chain adder.
// One operation in flight: accept, precharge, evaluate, then hold the result until taken.
module mcca_dyn_sequencer
  import mcca_pkg::*;
#(
  parameter int unsigned SIZE             = SIZE_DEF,
  parameter int unsigned PRECHARGE_CYCLES = PRECH_DEF,
  parameter int unsigned EVAL_CYCLES      = EVAL_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] in_a,
  input  logic [SIZE-1:0] in_b,
  input  logic            in_cin,
  output logic [SIZE-1:0] add_a,
  output logic [SIZE-1:0] add_b,
  output logic            add_cin,
  output logic            add_eval,
  input  logic [SIZE-1:0] add_sum,
  input  logic            add_cout,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] out_sum,
  output logic            out_cout,
  output logic            out_ovf,
  output logic            busy
);

  localparam int unsigned CW = cnt_width(PRECHARGE_CYCLES, EVAL_CYCLES);
  localparam logic [CW-1:0] PRE_LOAD  = CW'(PRECHARGE_CYCLES - 1);
  localparam logic [CW-1:0] EVAL_LOAD = CW'(EVAL_CYCLES - 1);

  if (((SIZE % 4) != 0) || (SIZE == 0) || (PRECHARGE_CYCLES < 1) || (EVAL_CYCLES < 1)) begin : g_bad_param
    $error("mcca_dyn_sequencer: SIZE must be a nonzero multiple of 4 and phase cycle counts >= 1");
  end

  state_e          r_state;
  logic [SIZE-1:0] r_add_a;
  logic [SIZE-1:0] r_add_b;
  logic            r_add_cin;
  logic            r_add_eval;
  logic            r_out_valid;
  logic [SIZE-1:0] r_out_sum;
  logic            r_out_cout;
  logic            r_out_ovf;

  logic            w_accept;
  logic            w_done;
  logic            w_load;
  logic [CW-1:0]   w_load_val;
  logic            w_en;
  logic            w_ovf;

  assign in_ready = rst_n && (r_state == IDLE);
  assign w_accept = in_valid && in_ready;

  // Timer is reloaded on entry to each timed phase.
  always_comb begin
    w_load     = 1'b0;
    w_load_val = PRE_LOAD;
    w_en       = 1'b0;
    case (r_state)
      IDLE: begin
        w_load     = w_accept;
        w_load_val = PRE_LOAD;
      end
      PRECH: begin
        w_en       = 1'b1;
        w_load     = w_done;
        w_load_val = EVAL_LOAD;
      end
      EVAL: begin
        w_en = 1'b1;
      end
      default: begin
        w_load = 1'b0;
      end
    endcase
  end

  mcca_phase_timer #(
    .CW (CW)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_en       (w_en),
    .o_done_c   (w_done)
  );

  assign w_ovf = (r_add_a[SIZE-1] == r_add_b[SIZE-1]) && (add_sum[SIZE-1] != r_add_a[SIZE-1]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_add_a     <= '0;
      r_add_b     <= '0;
      r_add_cin   <= 1'b0;
      r_add_eval  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_cout  <= 1'b0;
      r_out_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_add_a   <= in_a;
            r_add_b   <= in_b;
            r_add_cin <= in_cin;
            r_state   <= PRECH;
          end
        end
        PRECH: begin
          if (w_done) begin
            r_add_eval <= 1'b1;
            r_state    <= EVAL;
          end
        end
        EVAL: begin
          // Sample the settled chain on the edge that ends evaluate.
          if (w_done) begin
            r_out_sum   <= add_sum;
            r_out_cout  <= add_cout;
            r_out_ovf   <= w_ovf;
            r_out_valid <= 1'b1;
            r_add_eval  <= 1'b0;
            r_state     <= RESP;
          end
        end
        RESP: begin
          if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign add_a     = r_add_a;
  assign add_b     = r_add_b;
  assign add_cin   = r_add_cin;
  assign add_eval  = r_add_eval;
  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_cout  = r_out_cout;
  assign out_ovf   = r_out_ovf;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_mcca_dyn_sequencer.sv
// Bench for mcca_dyn_sequencer with a behavioural adder that only gives the
// true sum while add_eval is high (complemented garbage otherwise).
module tb_mcca_dyn_sequencer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_cin;
  logic [15:0] add_a;
  logic [15:0] add_b;
  logic        add_cin;
  logic        add_eval;
  logic [15:0] add_sum;
  logic        add_cout;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_cout;
  logic        out_ovf;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [16:0] adder_res;
  assign adder_res = {1'b0, add_a} + {1'b0, add_b} + 17'(add_cin);
  assign {add_cout, add_sum} = add_eval ? adder_res : ~adder_res;

  mcca_dyn_sequencer #(
    .SIZE             (16),
    .PRECHARGE_CYCLES (1),
    .EVAL_CYCLES      (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_eval  (add_eval),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // One full transaction with out_ready held low until the result is seen.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                        output logic [15:0] s, output logic co, output logic ov,
                        output int lat, output int ev);
    int w;
    in_a = a; in_b = b; in_cin = c; in_valid = 1'b1; out_ready = 1'b0;
    w = 0;
    while (!in_ready && w < 50) begin tick(); w++; end
    chk("accept_wait", 32'(w < 50), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("add_a_latched", 32'(add_a), 32'(a));
    chk("add_b_latched", 32'(add_b), 32'(b));
    lat = 0; ev = 0;
    while (!out_valid && lat < 50) begin
      if (add_eval) ev++;
      tick();
      lat++;
    end
    s = out_sum; co = out_cout; ov = out_ovf;
    chk("eval_low_in_resp", 32'(add_eval), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("resp_cleared", 32'(out_valid), 32'd0);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  typedef struct packed {
    logic [15:0] s;
    logic        co;
    logic        ov;
  } exp_t;

  vec_t tbl [7];
  exp_t q [$];

  initial begin
    logic [15:0] s;
    logic        co;
    logic        ov;
    int          lat;
    int          ev;
    int          w;

    tbl[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[2] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1};
    tbl[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[4] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    tbl[5] = '{16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[6] = '{16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1};

    // T1 reset with in_valid asserted
    rst_n = 1'b0; in_valid = 1'b1; in_a = 16'h1111; in_b = 16'h2222; in_cin = 1'b1; out_ready = 1'b0;
    repeat (3) begin
      tick();
      chk("rst_in_ready", 32'(in_ready), 32'd0);
    end
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_add_eval", 32'(add_eval), 32'd0);
    chk("rst_add_a", 32'(add_a), 32'd0);
    chk("rst_add_cin", 32'(add_cin), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sum", 32'(out_sum), 32'd0);
    chk("rst_out_flags", 32'({out_cout, out_ovf}), 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", 32'(in_ready), 32'd1);
    chk("post_rst_idle", 32'(busy), 32'd0);

    // T2/T3 table of directed operands, latency and evaluate width
    for (int i = 0; i < 7; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].cin, s, co, ov, lat, ev);
      chk($sformatf("vec%0d_sum", i), 32'(s), 32'(tbl[i].s));
      chk($sformatf("vec%0d_cout", i), 32'(co), 32'(tbl[i].co));
      chk($sformatf("vec%0d_ovf", i), 32'(ov), 32'(tbl[i].ov));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
      chk($sformatf("vec%0d_eval_cycles", i), 32'(ev), 32'd2);
    end

    // T4 backpressure with a second request pending
    in_a = 16'h0102; in_b = 16'h0304; in_cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    w = 0;
    while (!in_ready && w < 50) begin tick(); w++; end
    tick();
    in_a = 16'hAAAA; in_b = 16'h1111; in_cin = 1'b0;
    w = 0;
    while (!out_valid && w < 50) begin tick(); w++; end
    chk("bp_first_result_seen", 32'(w < 50), 32'd1);
    repeat (5) begin
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_sum", 32'(out_sum), 32'h0406);
      chk("bp_add_a", 32'(add_a), 32'h0102);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_handshake_clear", 32'(out_valid), 32'd0);
    chk("bp_ready_after", 32'(in_ready), 32'd1);
    chk("bp_not_yet_taken", 32'(add_a), 32'h0102);
    tick();
    in_valid = 1'b0;
    chk("bp_second_taken", 32'(add_a), 32'hAAAA);
    chk("bp_second_busy", 32'(busy), 32'd1);
    w = 0;
    while (!out_valid && w < 50) begin tick(); w++; end
    chk("bp_second_sum", 32'(out_sum), 32'hBBBB);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // T5 reset while evaluating
    in_a = 16'h0F0F; in_b = 16'h0101; in_cin = 1'b0; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 50) begin tick(); w++; end
    tick();
    in_valid = 1'b0;
    tick();
    chk("mid_eval_high", 32'(add_eval), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_eval", 32'(add_eval), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_add_a", 32'(add_a), 32'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (6) begin
      tick();
      chk("mid_rst_no_valid", 32'(out_valid), 32'd0);
    end
    run_op(16'h1234, 16'h4321, 1'b0, s, co, ov, lat, ev);
    chk("mid_rst_next_sum", 32'(s), 32'h5555);
    chk("mid_rst_next_flags", 32'({co, ov}), 32'd0);

    // T6 random stream against a queue model
    begin
      int   issued;
      int   got;
      int   cyc;
      logic pend;
      logic acc;
      logic prev_busy;
      logic [15:0] prev_a;
      logic [16:0] r;
      exp_t e;
      issued = 0; got = 0; cyc = 0; pend = 1'b0; prev_busy = 1'b0; prev_a = add_a;
      in_valid = 1'b0;
      while (got < 200 && cyc < 20000) begin
        if (!pend && issued < 200 && $urandom_range(0, 3) != 0) begin
          in_a = 16'($urandom); in_b = 16'($urandom); in_cin = 1'($urandom);
          in_valid = 1'b1;
          pend = 1'b1;
        end
        out_ready = ($urandom_range(0, 2) != 0);
        acc = in_valid && in_ready;
        if (acc) begin
          r = {1'b0, in_a} + {1'b0, in_b} + 17'(in_cin);
          e.s  = r[15:0];
          e.co = r[16];
          e.ov = (in_a[15] == in_b[15]) && (r[15] != in_a[15]);
          q.push_back(e);
          issued++;
          pend = 1'b0;
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            chk("stream_unexpected_result", 32'd1, 32'd0);
          end else begin
            e = q.pop_front();
            chk($sformatf("stream%0d_result", got), 32'({out_cout, out_ovf, out_sum}), 32'({e.co, e.ov, e.s}));
          end
          got++;
        end
        if (prev_busy && busy) chk("stream_operand_hold", 32'(add_a), 32'(prev_a));
        prev_busy = busy;
        prev_a = add_a;
        tick();
        cyc++;
        if (acc) in_valid = 1'b0;
      end
      chk("stream_count", 32'(got), 32'd200);
      chk("stream_issued", 32'(issued), 32'd200);
      chk("stream_queue_empty", 32'(q.size()), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
